// File: rtl/shift_pkg.sv
// Shared encodings and default sizes for the multi-cycle shift sequencer.
package shift_pkg;

  localparam int unsigned DefWidth  = 32;
  localparam int unsigned DefShamtW = 5;

  // op 2'b10 is reserved and falls through to SLL in the step logic.
  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_sequencer_if.sv
// Command/response bundle between the execute stage and the shift sequencer.
interface shift_sequencer_if
  import shift_pkg::*;
#(
  parameter int unsigned Width  = DefWidth,
  parameter int unsigned ShamtW = DefShamtW
);

  logic              start;
  logic [1:0]        op;
  logic [Width-1:0]  operand;
  logic [ShamtW-1:0] shamt;
  logic              flush;
  logic              busy;
  logic              done;
  logic [Width-1:0]  result;

  modport master (
    output start, op, operand, shamt, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, op, operand, shamt, flush,
    output busy, done, result
  );

endinterface

// File: rtl/shift_step.sv
// One-bit shift step of the working register for SLL, SRL and SRA.
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned Width = DefWidth
) (
  input  logic [Width-1:0] work_i,
  input  logic [1:0]       op_i,
  output logic [Width-1:0] work_o
);

  always_comb begin
    work_o = {work_i[Width-2:0], 1'b0};
    case (op_i)
      OP_SRL:  work_o = {1'b0, work_i[Width-1:1]};
      OP_SRA:  work_o = {work_i[Width-1], work_i[Width-1:1]};
      default: work_o = {work_i[Width-2:0], 1'b0};
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: moves the working register one bit per clock until the
// captured amount is exhausted, then pulses done with the result.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int unsigned Width  = DefWidth,
  parameter int unsigned ShamtW = DefShamtW
) (
  input  logic             clk,
  input  logic             reset,
  shift_sequencer_if.slave bus
);

  state_e            state_q, state_d;
  logic [Width-1:0]  work_q, work_d;
  logic [ShamtW-1:0] cnt_q, cnt_d;
  logic [1:0]        opr_q, opr_d;
  logic [Width-1:0]  step_work;

  shift_step #(
    .Width(Width)
  ) u_step (
    .work_i(work_q),
    .op_i  (opr_q),
    .work_o(step_work)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      work_q  <= '0;
      cnt_q   <= '0;
      opr_q   <= OP_SLL;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      opr_q   <= opr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    opr_d   = opr_q;
    unique case (state_q)
      StIdle: begin
        // flush outranks start: a command arriving with a flush is dropped
        if (bus.start && !bus.flush) begin
          work_d  = bus.operand;
          cnt_d   = bus.shamt;
          opr_d   = bus.op;
          state_d = (bus.shamt == '0) ? StDone : StShift;
        end
      end
      StShift: begin
        if (bus.flush) begin
          state_d = StIdle;
        end else begin
          work_d = step_work;
          cnt_d  = cnt_q - ShamtW'(1);
          if (cnt_q == ShamtW'(1)) state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign bus.busy   = (state_q != StIdle);
  assign bus.done   = (state_q == StDone);
  assign bus.result = work_q;

endmodule
